// File: rtl/ascii_digit_capture.sv
// ascii_digit_capture: collects one or two ASCII digits closed by a CR byte
// and hands the number downstream over a valid/ready pair.
module ascii_digit_capture #(
  parameter logic [7:0] CR_CODE = 8'h0D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] Tens,
  output logic [3:0] Units,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic       ovr
);

  typedef enum logic [1:0] {
    S_TENS,
    S_ONE,
    S_TWO,
    S_HOLD
  } state_t;

  state_t     state, state_d, cur;
  logic [3:0] d0, d0_d;
  logic [3:0] d1, d1_d;
  logic [6:0] tens_d;
  logic [3:0] units_d;
  logic       ov_d, err_d, ovr_d;
  logic       is_cr, is_dig, take;
  logic [3:0] dv;

  assign is_cr  = (rx_data == CR_CODE);
  assign is_dig = (rx_data >= 8'h30) && (rx_data <= 8'h39) && !is_cr;
  assign dv     = rx_data[3:0];

  always_comb begin
    state_d = state;
    cur     = state;
    d0_d    = d0;
    d1_d    = d1;
    tens_d  = Tens;
    units_d = Units;
    ov_d    = out_valid;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    take    = rx_valid;

    // an accept frees the block, so a same-cycle byte starts a new number
    if (state == S_HOLD) begin
      if (out_ready) begin
        ov_d    = 1'b0;
        cur     = S_TENS;
        state_d = S_TENS;
      end else begin
        ovr_d = rx_valid;
        take  = 1'b0;
      end
    end

    if (take) begin
      unique case (cur)
        S_TENS: begin
          unique case (1'b1)
            is_dig: begin
              d0_d    = dv;
              state_d = S_ONE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_TENS;
            end
          endcase
        end
        S_ONE: begin
          unique case (1'b1)
            is_dig: begin
              d1_d    = dv;
              state_d = S_TWO;
            end
            is_cr: begin
              tens_d  = 7'd0;
              units_d = d0;
              ov_d    = 1'b1;
              state_d = S_HOLD;
            end
            default: begin
              err_d   = 1'b1;
              d0_d    = 4'd0;
              d1_d    = 4'd0;
              state_d = S_TENS;
            end
          endcase
        end
        S_TWO: begin
          unique case (1'b1)
            is_cr: begin
              tens_d  = {3'b000, d0};
              units_d = d1;
              ov_d    = 1'b1;
              state_d = S_HOLD;
            end
            default: begin
              err_d   = 1'b1;
              d0_d    = 4'd0;
              d1_d    = 4'd0;
              state_d = S_TENS;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_TENS;
      d0        <= 4'd0;
      d1        <= 4'd0;
      Tens      <= 7'd0;
      Units     <= 4'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_d;
      d0        <= d0_d;
      d1        <= d1_d;
      Tens      <= tens_d;
      Units     <= units_d;
      out_valid <= ov_d;
      err       <= err_d;
      ovr       <= ovr_d;
    end
  end

endmodule
